// File: rtl/ckt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ckt_pkg
//  Description : Shared types and constants for the 3-input truth-table
//                sweeper (FSM state type, default settle time, majority TT).
//  Revision    : 1.0  initial release
// ============================================================================
package ckt_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Default settle time per input vector, in clk cycles (legal 1..255)
  localparam int unsigned HOLD_CYCLES_DEF = 10;

  // Truth table of a 3-input majority gate, bit i = y for {a,b,c} == i
  localparam logic [7:0] MAJ3_TT = 8'b1110_1000;

  // Number of input vectors swept ({a,b,c} covers 0..7)
  localparam int unsigned NUM_VEC = 8;

endpackage : ckt_pkg
`default_nettype wire

// File: rtl/ckt_sweep_if.sv
`default_nettype none
// ============================================================================
//  Module      : ckt_sweep_if
//  Description : Signal bundle between the sweeper and the circuit under
//                sweep / its controller.
//                  start     - one-cycle sweep request
//                  a,b,c     - stimulus bits (a = MSB of vector index)
//                  y         - response of the circuit under sweep
//                  busy/done - sweep running / result held
//                  result    - captured y per vector
//                  mismatch  - result XOR expected truth table
//                  err_count - number of set mismatch bits
//                  pass      - done with no mismatches
//                master : the sweeper side
//                slave  : the requester / circuit side
//  Revision    : 1.0  initial release
// ============================================================================
interface ckt_sweep_if;
  logic       start;
  logic       a;
  logic       b;
  logic       c;
  logic       y;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] mismatch;
  logic [3:0] err_count;
  logic       pass;

  modport master (
    input  start, y,
    output a, b, c, busy, done, result, mismatch, err_count, pass
  );

  modport slave (
    output start, y,
    input  a, b, c, busy, done, result, mismatch, err_count, pass
  );
endinterface : ckt_sweep_if
`default_nettype wire

// File: rtl/ckt_sweep_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ckt_sweep_timer
//  Description : Settle counter. Counts enabled cycles 0..HOLD_CYCLES-1 and
//                flags the last one; wraps to 0 after the terminal count.
//                  clk    - clock
//                  rst    - synchronous active-high reset
//                  clear  - force the count back to 0 (priority over enable)
//                  enable - advance the count
//                  tc_o   - high on an enabled cycle whose count is
//                           HOLD_CYCLES-1
//  Revision    : 1.0  initial release
// ============================================================================
module ckt_sweep_timer
  import ckt_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear,
  input  wire logic enable,
  output logic      tc_o
);

  localparam logic [7:0] TC_VAL = 8'(HOLD_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       w_at_tc;

  assign w_at_tc = (cnt_q == TC_VAL);
  assign tc_o    = enable && w_at_tc;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (enable) begin
      cnt_d = w_at_tc ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : ckt_sweep_timer
`default_nettype wire

// File: rtl/ckt_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : ckt_sweep
//  Description : Exhaustive 3-input truth-table sweeper. On start, drives
//                {a,b,c} through 0..7, holds each vector HOLD_CYCLES cycles,
//                samples y on the last cycle of each vector and compares the
//                captured table against EXP_TT.
//                  clk  - clock
//                  rst  - synchronous active-high reset
//                  bus  - ckt_sweep_if master (start, y in; stimulus,
//                         status and results out)
//  Revision    : 1.0  initial release
// ============================================================================
module ckt_sweep
  import ckt_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter logic [7:0]  EXP_TT      = MAJ3_TT
) (
  input  wire logic    clk,
  input  wire logic    rst,
  ckt_sweep_if.master  bus
);

  state_e     state_q;
  state_e     state_d;
  logic [2:0] idx_q;
  logic [2:0] idx_d;
  logic [7:0] result_q;
  logic [7:0] result_d;
  logic [7:0] mismatch_q;
  logic [7:0] mismatch_d;
  logic [3:0] err_q;
  logic [3:0] err_d;

  logic       w_tc;
  logic       w_clear;
  logic       w_enable;
  logic       w_miss;
  logic       w_driving;

  assign w_driving = (state_q == DRIVE);
  assign w_enable  = w_driving;
  // The settle counter restarts only when a start is actually accepted.
  assign w_clear   = bus.start && !w_driving;
  assign w_miss    = bus.y ^ EXP_TT[idx_q];

  ckt_sweep_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_clear),
    .enable (w_enable),
    .tc_o   (w_tc)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    result_d   = result_q;
    mismatch_d = mismatch_q;
    err_d      = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d    = DRIVE;
          idx_d      = 3'd0;
          result_d   = 8'd0;
          mismatch_d = 8'd0;
          err_d      = 4'd0;
        end
      end
      DRIVE: begin
        // start is deliberately ignored here: no restart mid-sweep.
        if (w_tc) begin
          result_d[idx_q]   = bus.y;
          mismatch_d[idx_q] = w_miss;
          if (w_miss) begin
            err_d = err_q + 4'd1;
          end
          // Last vector ends the sweep; the index never wraps.
          if (idx_q == 3'd7) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      result_q   <= 8'd0;
      mismatch_q <= 8'd0;
      err_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  // Outputs come from registers only; y never reaches an output directly.
  assign bus.a         = w_driving ? idx_q[2] : 1'b0;
  assign bus.b         = w_driving ? idx_q[1] : 1'b0;
  assign bus.c         = w_driving ? idx_q[0] : 1'b0;
  assign bus.busy      = w_driving;
  assign bus.done      = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.err_count = err_q;
  assign bus.pass      = (state_q == DONE) && (err_q == 4'd0);

endmodule : ckt_sweep
`default_nettype wire

// File: tb/tb_ckt_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ckt_sweep
//  Description : Self-checking bench for ckt_sweep. Three instances with
//                HOLD_CYCLES 10, 3 and 1; the circuit under sweep is modelled
//                per instance as majority / stuck-at-0 / stuck-at-1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ckt_sweep;
  import ckt_pkg::*;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] mm;
    logic [3:0] ec;
    logic       ps;
  } exp_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [2:0] abc;
    logic [7:0] res;
    logic [7:0] mm;
    logic [3:0] ec;
    logic       ps;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ckt_sweep_if if10 ();
  ckt_sweep_if if3 ();
  ckt_sweep_if if1 ();

  // 0 = majority of a,b,c ; 1 = stuck at 0 ; 2 = stuck at 1
  int mode10 = 0;
  int mode3  = 0;
  int mode1  = 0;

  int n_vec = 0;
  int n_bad = 0;

  exp_t       sbq[$];
  logic [2:0] abcq[$];

  function automatic logic resp(input int m, input logic a, input logic b, input logic c);
    case (m)
      0:       return (a & b) | (a & c) | (b & c);
      1:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign if10.y = resp(mode10, if10.a, if10.b, if10.c);
  assign if3.y  = resp(mode3,  if3.a,  if3.b,  if3.c);
  assign if1.y  = resp(mode1,  if1.a,  if1.b,  if1.c);

  ckt_sweep #(.HOLD_CYCLES(10), .EXP_TT(MAJ3_TT)) dut10 (.clk(clk), .rst(rst), .bus(if10.master));
  ckt_sweep #(.HOLD_CYCLES(3),  .EXP_TT(MAJ3_TT)) dut3  (.clk(clk), .rst(rst), .bus(if3.master));
  ckt_sweep #(.HOLD_CYCLES(1),  .EXP_TT(MAJ3_TT)) dut1  (.clk(clk), .rst(rst), .bus(if1.master));

  function automatic obs_t snap(input int sel);
    case (sel)
      0: return {if10.busy, if10.done, {if10.a, if10.b, if10.c}, if10.result,
                 if10.mismatch, if10.err_count, if10.pass};
      1: return {if3.busy, if3.done, {if3.a, if3.b, if3.c}, if3.result,
                 if3.mismatch, if3.err_count, if3.pass};
      default: return {if1.busy, if1.done, {if1.a, if1.b, if1.c}, if1.result,
                       if1.mismatch, if1.err_count, if1.pass};
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       if10.start = v;
      1:       if3.start  = v;
      default: if1.start  = v;
    endcase
  endtask

  task automatic set_mode(input int sel, input int m);
    case (sel)
      0:       mode10 = m;
      1:       mode3  = m;
      default: mode1  = m;
    endcase
  endtask

  // Expected sweep outcome built from the vector index and the response model
  function automatic exp_t model(input logic [7:0] tt, input int m);
    exp_t e;
    logic [2:0] vb;
    e = '0;
    for (int v = 0; v < 8; v++) begin
      vb = 3'(v);
      e.res[v] = resp(m, vb[2], vb[1], vb[0]);
    end
    e.mm = e.res ^ tt;
    for (int v = 0; v < 8; v++) begin
      if (e.mm[v]) e.ec = e.ec + 4'd1;
    end
    e.ps = (e.ec == 4'd0);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete sweep: pulse start, follow the stimulus cycle by cycle,
  // then compare timing and results. restart_at >= 0 re-pulses start at
  // that cycle of the sweep.
  task automatic do_sweep(input int sel, input int hold, input int m,
                          input logic [7:0] tt, input int restart_at,
                          input string name);
    exp_t       e;
    obs_t       o;
    logic [2:0] ea;
    int         cyc;
    logic       busy_ok;
    set_mode(sel, m);
    sbq.push_back(model(tt, m));
    for (int v = 0; v < 8; v++)
      for (int k = 0; k < hold; k++) abcq.push_back(3'(v));
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    o = snap(sel);
    n_vec++;
    if (o.busy !== 1'b1 || o.res !== 8'h00 || o.mm !== 8'h00 || o.ec !== 4'd0) begin
      n_bad++;
      $display("FAIL %s entry: got busy=%b res=%h mm=%h ec=%0d, expected busy=1 res=00 mm=00 ec=0",
               name, o.busy, o.res, o.mm, o.ec);
    end
    cyc     = 0;
    busy_ok = 1'b1;
    while (o.done !== 1'b1 && cyc < 8 * hold + 16) begin
      if (abcq.size() > 0) begin
        ea = abcq.pop_front();
        n_vec++;
        if (o.abc !== ea) begin
          n_bad++;
          $display("FAIL %s abc@%0d: got %b expected %b", name, cyc, o.abc, ea);
        end
      end
      if (o.busy !== 1'b1) busy_ok = 1'b0;
      set_start(sel, cyc == restart_at);
      tick();
      cyc++;
      o = snap(sel);
    end
    set_start(sel, 1'b0);
    abcq.delete();
    n_vec++;
    if (cyc != 8 * hold) begin
      n_bad++;
      $display("FAIL %s latency: got %0d cycles expected %0d", name, cyc, 8 * hold);
    end
    n_vec++;
    if (!busy_ok) begin
      n_bad++;
      $display("FAIL %s busy: got busy low during sweep expected high throughout", name);
    end
    e = sbq.pop_front();
    n_vec++;
    if ({o.res, o.mm, o.ec, o.ps} !== {e.res, e.mm, e.ec, e.ps}) begin
      n_bad++;
      $display("FAIL %s result: got res=%h mm=%h ec=%0d pass=%b expected res=%h mm=%h ec=%0d pass=%b",
               name, o.res, o.mm, o.ec, o.ps, e.res, e.mm, e.ec, e.ps);
    end
    repeat (3) tick();
    o = snap(sel);
    n_vec++;
    if (o.done !== 1'b1 || o.busy !== 1'b0 || o.abc !== 3'b000 ||
        o.res !== e.res || o.mm !== e.mm || o.ec !== e.ec) begin
      n_bad++;
      $display("FAIL %s hold: got done=%b busy=%b abc=%b res=%h mm=%h ec=%0d expected done=1 busy=0 abc=000 res=%h mm=%h ec=%0d",
               name, o.done, o.busy, o.abc, o.res, o.mm, o.ec, e.res, e.mm, e.ec);
    end
  endtask

  task automatic test_reset;
    obs_t o;
    rst = 1'b1;
    repeat (3) tick();
    for (int s = 0; s < 3; s++) begin
      o = snap(s);
      n_vec++;
      if (o !== '0) begin
        n_bad++;
        $display("FAIL reset dut%0d: got %h expected 0", s, o);
      end
    end
    // reset wins over a simultaneous start
    set_start(0, 1'b1);
    tick();
    o = snap(0);
    n_vec++;
    if (o.busy !== 1'b0 || o.done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_prio: got busy=%b done=%b expected busy=0 done=0", o.busy, o.done);
    end
    set_start(0, 1'b0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_majority;
    do_sweep(0, 10, 0, MAJ3_TT, -1, "maj10");
  endtask

  task automatic test_stuck0;
    do_sweep(0, 10, 1, MAJ3_TT, -1, "stuck0");
  endtask

  task automatic test_order;
    do_sweep(1, 3, 0, MAJ3_TT, -1, "order3");
  endtask

  task automatic test_reset_mid;
    obs_t o;
    int   cyc;
    set_mode(0, 0);
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    cyc = 0;
    while (cyc < 52) begin
      tick();
      cyc++;
    end
    // vector 5, settle cycle 2: vectors 0..4 captured, only vector 3 is 1
    o = snap(0);
    n_vec++;
    if (o.busy !== 1'b1 || o.abc !== 3'b101 || o.res !== 8'h08) begin
      n_bad++;
      $display("FAIL rst_mid pre: got busy=%b abc=%b res=%h expected busy=1 abc=101 res=08",
               o.busy, o.abc, o.res);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    o = snap(0);
    n_vec++;
    if (o !== '0) begin
      n_bad++;
      $display("FAIL rst_mid: got %h expected 0", o);
    end
    repeat (4) tick();
    o = snap(0);
    n_vec++;
    if (o !== '0) begin
      n_bad++;
      $display("FAIL no_resume: got %h expected 0", o);
    end
    do_sweep(0, 10, 0, MAJ3_TT, -1, "after_rst");
  endtask

  task automatic test_back_to_back;
    do_sweep(0, 10, 0, MAJ3_TT, 30, "busy_start");
    // restart from DONE with a different response; entry must clear results
    do_sweep(0, 10, 1, MAJ3_TT, -1, "restart_done");
  endtask

  task automatic test_min_hold;
    do_sweep(2, 1, 2, MAJ3_TT, -1, "minhold");
  endtask

  initial begin
    if10.start = 1'b0;
    if3.start  = 1'b0;
    if1.start  = 1'b0;
    test_reset();
    test_majority();
    test_stuck0();
    test_order();
    test_reset_mid();
    test_back_to_back();
    test_min_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_ckt_sweep
`default_nettype wire
